// File: rtl/ft_regbank_pkg.sv
// rtl/ft_regbank_pkg.sv - command codes, frame state encoding and default-word helper for ft_regbank
package ft_regbank_pkg;

  localparam logic [3:0] CMD_WRITE = 4'h5;
  localparam logic [3:0] CMD_READ  = 4'hA;

  // Widest register word the default-word helper can fill
  localparam int MAX_DW = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_COMMIT,
    ST_RDATA
  } state_t;

  // Repeat the 32-bit pattern across MAX_DW bits; callers keep the low DW bits,
  // which replicates for wide registers and truncates for narrow ones.
  function automatic logic [MAX_DW-1:0] fit_default(input logic [31:0] pattern);
    logic [MAX_DW-1:0] word;
    for (int i = 0; i < MAX_DW / 32; i++) begin
      word[i*32 +: 32] = pattern;
    end
    return word;
  endfunction

endpackage

// File: rtl/ft_regbank_frame.sv
// rtl/ft_regbank_frame.sv - command/address/data frame FSM with byte shifters; FT_REGBANK_TIMEOUT_EN adds an inter-byte timeout
module ft_regbank_frame
  import ft_regbank_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 1024,
  localparam int DW        = 8 * DATA_BYTES
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  input  logic [DW-1:0] i_snap,
  output logic [7:0]    o_adr,
  output logic [DW-1:0] o_wdata,
  output logic          o_commit,
  output logic          o_err,
  output logic          o_busy
);

  localparam int CW = $clog2(DATA_BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

  state_t        r_state;
  logic          r_is_rd;
  logic [7:0]    r_adr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_wshift;
  logic [DW-1:0] r_tshift;
  logic          r_rx_ready;
  logic          r_tx_valid;
  logic          r_busy;
  logic          r_commit;
  logic          r_err;

  logic w_rx_hs;
  logic w_tx_hs;
  logic w_timeout;

  assign w_rx_hs = i_rx_valid & r_rx_ready;
  assign w_tx_hs = r_tx_valid & i_tx_ready;

`ifdef FT_REGBANK_TIMEOUT_EN
  logic [15:0] r_idle;
  logic        w_counting;

  assign w_counting = (r_state == ST_ADDR) || (r_state == ST_WDATA) || (r_state == ST_RDATA);
  assign w_timeout  = w_counting && !w_rx_hs && !w_tx_hs && (r_idle == 16'(TIMEOUT - 1));

  // Idle counter: restarts on every handshake and stays cleared while not waiting on the host
  always_ff @(posedge i_clk) begin
    if (i_reset || !w_counting || w_rx_hs || w_tx_hs || w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 16'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  // Frame FSM: outputs are registered alongside each state transition
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_is_rd    <= 1'b0;
      r_adr      <= '0;
      r_cnt      <= '0;
      r_wshift   <= '0;
      r_tshift   <= '0;
      r_rx_ready <= 1'b1;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_commit   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      r_err    <= 1'b0;
      if (w_timeout) begin
        r_state    <= ST_IDLE;
        r_wshift   <= '0;
        r_tshift   <= '0;
        r_rx_ready <= 1'b1;
        r_tx_valid <= 1'b0;
        r_busy     <= 1'b0;
        r_err      <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rx_hs) begin
              if ((i_rx_data[3:0] == CMD_WRITE) || (i_rx_data[3:0] == CMD_READ)) begin
                r_state <= ST_ADDR;
                r_is_rd <= (i_rx_data[3:0] == CMD_READ);
                r_busy  <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_ADDR: begin
            if (w_rx_hs) begin
              r_adr <= i_rx_data;
              r_cnt <= '0;
              if (r_is_rd) begin
                // Snapshot is taken on the address edge so later source changes cannot tear it
                r_tshift   <= i_snap;
                r_state    <= ST_RDATA;
                r_rx_ready <= 1'b0;
                r_tx_valid <= 1'b1;
              end else begin
                r_state <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (w_rx_hs) begin
              // Little-endian: the first byte drifts down to bits [7:0] after the last shift
              r_wshift <= (r_wshift >> 8) | (DW'(i_rx_data) << (DW - 8));
              r_cnt    <= r_cnt + CW'(1);
              if (r_cnt == LAST) begin
                r_state    <= ST_COMMIT;
                r_rx_ready <= 1'b0;
                r_commit   <= 1'b1;
              end
            end
          end
          ST_COMMIT: begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
          ST_RDATA: begin
            if (w_tx_hs) begin
              r_tshift <= r_tshift >> 8;
              r_cnt    <= r_cnt + CW'(1);
              if (r_cnt == LAST) begin
                r_state    <= ST_IDLE;
                r_tx_valid <= 1'b0;
                r_rx_ready <= 1'b1;
                r_busy     <= 1'b0;
              end
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b1;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tshift[7:0];
  assign o_adr      = r_adr;
  assign o_wdata    = r_wshift;
  assign o_commit   = r_commit;
  assign o_err      = r_err;
  assign o_busy     = r_busy;

endmodule

// File: rtl/ft_regbank.sv
// rtl/ft_regbank.sv - host register bank over a byte stream; FT_REGBANK_TIMEOUT_EN enables the inter-byte timeout
module ft_regbank
  import ft_regbank_pkg::*;
#(
  parameter int                            NREG       = 16,
  parameter int                            DATA_BYTES = 4,
  parameter logic [NREG*DATA_BYTES*8-1:0]  RESET_VAL  = '0,
  parameter logic [NREG-1:0]               RO_MASK    = '0,
  parameter logic [NREG*DATA_BYTES*8-1:0]  PULSE_MASK = '0,
  parameter logic [31:0]                   DEFAULT_RD = 32'hDEADBEEF,
  parameter int                            TIMEOUT    = 1024,
  localparam int                           ADR_W      = $clog2(NREG),
  localparam int                           DW         = 8 * DATA_BYTES
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [NREG*DW-1:0] o_reg_q,
  input  logic [NREG*DW-1:0] i_reg_d,
  output logic [NREG-1:0]    o_wr_strobe,
  output logic [7:0]         o_err_cnt,
  output logic               o_busy
);

  localparam logic [DW-1:0] DEF_WORD = DW'(fit_default(DEFAULT_RD));

  logic [DW-1:0]    r_reg [NREG];
  logic [NREG-1:0]  r_wr_strobe;
  logic [7:0]       r_err_cnt;

  logic [DW-1:0]    w_snap;
  logic [DW-1:0]    w_wdata;
  logic [7:0]       w_adr;
  logic             w_commit;
  logic             w_frame_err;
  logic             w_writable;
  logic             w_err_inc;
  logic [ADR_W-1:0] w_rx_idx;
  logic [ADR_W-1:0] w_wr_idx;

  ft_regbank_frame #(
    .DATA_BYTES (DATA_BYTES),
    .TIMEOUT    (TIMEOUT)
  ) u_frame (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .i_snap     (w_snap),
    .o_adr      (w_adr),
    .o_wdata    (w_wdata),
    .o_commit   (w_commit),
    .o_err      (w_frame_err),
    .o_busy     (o_busy)
  );

  assign w_rx_idx   = i_rx_data[ADR_W-1:0];
  assign w_wr_idx   = w_adr[ADR_W-1:0];
  assign w_writable = (32'(w_adr) < NREG) && !RO_MASK[w_wr_idx];
  assign w_err_inc  = w_frame_err | (w_commit & ~w_writable);

  // Read source for the address byte on rx_data; the frame FSM latches it only on the read address edge
  always_comb begin
    w_snap = r_reg[w_rx_idx];
    if (32'(i_rx_data) >= NREG) begin
      w_snap = DEF_WORD;
    end else if (RO_MASK[w_rx_idx]) begin
      w_snap = i_reg_d[w_rx_idx*DW +: DW];
    end
  end

  // Register array: commit writes, then pulse bits drop on the edge the strobe is seen
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (i_reset) begin
        r_reg[i] <= RESET_VAL[i*DW +: DW];
      end else if (w_commit && w_writable && (w_wr_idx == ADR_W'(i))) begin
        r_reg[i] <= w_wdata;
      end else if (r_wr_strobe[i]) begin
        r_reg[i] <= r_reg[i] & ~PULSE_MASK[i*DW +: DW];
      end
    end
  end

  // One-cycle write strobe on the register accepted by the commit
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (i_reset) begin
        r_wr_strobe[i] <= 1'b0;
      end else begin
        r_wr_strobe[i] <= w_commit && w_writable && (w_wr_idx == ADR_W'(i));
      end
    end
  end

  // Saturating count of dropped commands, rejected writes and timeouts
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_cnt <= '0;
    end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign o_reg_q[g*DW +: DW] = r_reg[g];
  end

  assign o_wr_strobe = r_wr_strobe;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ft_regbank.sv
// tb/tb_ft_regbank.sv - scoreboard bench for ft_regbank; timeout scenario runs when FT_REGBANK_TIMEOUT_EN is defined
module tb_ft_regbank;

  localparam int NREG = 16;
  localparam int DW   = 32;
  localparam logic [NREG*DW-1:0] RV = {{(NREG*DW-32){1'b0}}, 32'h0BADC0DE} << (7*DW);
  localparam logic [NREG*DW-1:0] PM = {{(NREG*DW-32){1'b0}}, 32'h00000001};
  localparam logic [NREG-1:0]    RO = 16'h0020;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [NREG*DW-1:0] reg_q;
  logic [NREG*DW-1:0] reg_d = '0;
  logic [NREG-1:0]   wr_strobe;
  logic [7:0]        err_cnt;
  logic              busy;

  always #5 clk = ~clk;

  ft_regbank #(
    .NREG(NREG), .DATA_BYTES(4), .RESET_VAL(RV), .RO_MASK(RO),
    .PULSE_MASK(PM), .DEFAULT_RD(32'hDEADBEEF), .TIMEOUT(16)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready), .o_reg_q(reg_q), .i_reg_d(reg_d),
    .o_wr_strobe(wr_strobe), .o_err_cnt(err_cnt), .o_busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;
  logic [31:0] model [NREG];
  logic [7:0]  exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] get_q(input int i);
    return reg_q[i*DW +: DW];
  endfunction

  function automatic logic [31:0] expect_word(input logic [7:0] adr);
    if (int'(adr) >= NREG) return 32'hDEADBEEF;
    if (RO[adr[3:0]]) return reg_d[int'(adr[3:0])*DW +: DW];
    return model[adr[3:0]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = RV[i*DW +: DW];
    exp_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin tick(); n++; end
    n_tests++;
    if (n >= 50) begin n_fail++; $display("FAIL send_byte_wait rx_ready=%b exp=1", rx_ready); end
    tick();
    rx_valid = 1'b0;
  endtask

  // Returns in the COMMIT cycle (one #1 after the last data byte edge)
  task automatic write_frame(input logic [7:0] adr, input logic [31:0] data);
    send_byte(8'h05);
    send_byte(adr);
    for (int k = 0; k < 4; k++) send_byte(data[k*8 +: 8]);
    if (int'(adr) < NREG && !RO[adr[3:0]]) model[adr[3:0]] = data;
    else exp_err++;
  endtask

  task automatic start_read(input logic [7:0] cmd, input logic [7:0] adr);
    logic [31:0] w;
    send_byte(cmd);
    send_byte(adr);
    w = expect_word(adr);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[k*8 +: 8]);
    n_tests++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL read_latency tx_valid=%b exp=1", tx_valid); end
  endtask

  task automatic drain(input bit stall);
    logic [7:0] e;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (tx_valid !== 1'b1 && n < 50) begin tick(); n++; end
      n_tests++;
      if (n >= 50 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL drain_wait tx_valid=%b queued=%0d exp=valid", tx_valid, exp_q.size());
        return;
      end
      if (stall) begin
        tx_ready = 1'b0;
        tick();
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
          n_fail++; $display("FAIL tx_hold byte%0d got=%h/%b exp=%h/1", k, tx_data, tx_valid, exp_q[0]);
        end
      end
      tx_ready = 1'b1;
      e = exp_q.pop_front();
      n_tests++;
      if (tx_data !== e) begin n_fail++; $display("FAIL tx_byte%0d got=%h exp=%h", k, tx_data, e); end
      tick();
      tx_ready = 1'b0;
    end
    n_tests++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL read_end busy=%b rx_ready=%b exp=0/1", busy, rx_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    n_tests++; if (wr_strobe !== 16'h0) begin n_fail++; $display("FAIL reset_strobe got=%h exp=0", wr_strobe); end
    n_tests++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err got=%h exp=00", err_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (get_q(7) !== 32'h0BADC0DE) begin n_fail++; $display("FAIL reset_reg7 got=%h exp=0badc0de", get_q(7)); end
    n_tests++; if (get_q(3) !== 32'h0) begin n_fail++; $display("FAIL reset_reg3 got=%h exp=0", get_q(3)); end
  endtask

  task automatic test_write();
    write_frame(8'h03, 32'h12345678);
    n_tests++; if (busy !== 1'b1 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL commit_state busy=%b rx_ready=%b exp=1/0", busy, rx_ready); end
    n_tests++; if (get_q(3) !== 32'h0) begin n_fail++; $display("FAIL write_early got=%h exp=0", get_q(3)); end
    tick();
    n_tests++; if (get_q(3) !== 32'h12345678) begin n_fail++; $display("FAIL write_reg3 got=%h exp=12345678", get_q(3)); end
    n_tests++; if (wr_strobe !== 16'h0008) begin n_fail++; $display("FAIL write_strobe got=%h exp=0008", wr_strobe); end
    tick();
    n_tests++; if (wr_strobe !== 16'h0000) begin n_fail++; $display("FAIL strobe_width got=%h exp=0000", wr_strobe); end
  endtask

  task automatic test_read();
    start_read(8'h0A, 8'h03);
    drain(1'b1);
  endtask

  task automatic test_read_only();
    reg_d[5*DW +: DW] = 32'hCAFEF00D;
    start_read(8'h0A, 8'h05);
    drain(1'b0);
    write_frame(8'h05, 32'h11223344);
    tick();
    n_tests++; if (wr_strobe !== 16'h0) begin n_fail++; $display("FAIL ro_strobe got=%h exp=0", wr_strobe); end
    tick();
    n_tests++; if (get_q(5) !== model[5]) begin n_fail++; $display("FAIL ro_reg5 got=%h exp=%h", get_q(5), model[5]); end
    n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL ro_err got=%0d exp=%0d", err_cnt, exp_err); end
  endtask

  task automatic test_out_of_range();
    start_read(8'hFA, 8'h20);
    drain(1'b0);
    send_byte(8'h33);
    exp_err++;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badcmd_busy got=%b exp=0", busy); end
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badcmd_busy_late got=%b exp=0", busy); end
    n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL badcmd_err got=%0d exp=%0d", err_cnt, exp_err); end
  endtask

  task automatic test_snapshot();
    reg_d[5*DW +: DW] = 32'hCAFEF00D;
    start_read(8'h0A, 8'h05);
    reg_d[5*DW +: DW] = 32'h00000000;
    drain(1'b1);
  endtask

  task automatic test_pulse();
    write_frame(8'h00, 32'h00000001);
    model[0] = 32'h00000001 & ~PM[31:0];
    tick();
    n_tests++; if (get_q(0) !== 32'h00000001) begin n_fail++; $display("FAIL pulse_set got=%h exp=00000001", get_q(0)); end
    tick();
    n_tests++; if (get_q(0) !== model[0]) begin n_fail++; $display("FAIL pulse_clear got=%h exp=%h", get_q(0), model[0]); end
  endtask

  task automatic test_back_to_back();
    write_frame(8'h09, 32'hA5A55A5A);
    tick();
    n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_after_commit rx_ready=%b exp=1", rx_ready); end
    start_read(8'h0A, 8'h09);
    drain(1'b0);
    write_frame(8'h0A, 32'h01020304);
    start_read(8'h0A, 8'h0A);
    drain(1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int strobes = 0;
    send_byte(8'h05); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy got=%b exp=1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    n_tests++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL midframe_idle busy=%b rx_ready=%b exp=0/1", busy, rx_ready); end
    for (int k = 0; k < 6; k++) begin
      if (wr_strobe !== 16'h0) strobes++;
      tick();
    end
    n_tests++; if (strobes != 0) begin n_fail++; $display("FAIL midframe_strobe got=%0d exp=0", strobes); end
    n_tests++; if (get_q(4) !== model[4]) begin n_fail++; $display("FAIL midframe_reg4 got=%h exp=%h", get_q(4), model[4]); end
    n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL midframe_err got=%0d exp=%0d", err_cnt, exp_err); end
  endtask

`ifdef FT_REGBANK_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    send_byte(8'h05); send_byte(8'h02); send_byte(8'hAA);
    while (busy === 1'b1 && n < 40) begin tick(); n++; end
    exp_err++;
    n_tests++; if (n != 16) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
    tick(); tick();
    n_tests++; if (get_q(2) !== model[2]) begin n_fail++; $display("FAIL timeout_reg2 got=%h exp=%h", get_q(2), model[2]); end
    n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL timeout_err got=%0d exp=%0d", err_cnt, exp_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_only();
    test_out_of_range();
    test_snapshot();
    test_pulse();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef FT_REGBANK_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ft_regbank.md
# ft_regbank

Parametrised host register bank behind the FTDI 245 byte stream: decodes read/write command frames, holds NREG registers of DATA_BYTES bytes each, and returns coherent read snapshots. It is the successor to the fixed 4-bit-address, 32-bit serial register block. New features are parametrised depth and width, per-register read-back source selection, self-clearing pulse bits, frame error counting and an optional inter-byte timeout. It sits between the FT245 interface logic and the comparator-test control/status fabric.

## Interface
- NREG, 16: number of registers, 2..256; ADR_W = $clog2(NREG) is a localparam.
- DATA_BYTES, 4: bytes per register; DW = 8*DATA_BYTES.
- RESET_VAL, 0: flattened NREG*DW reset values; register i occupies [i*DW +: DW].
- RO_MASK, 0: NREG bits; bit i=1 means reads of register i return reg_d slice i and host writes to it are discarded.
- PULSE_MASK, 0: flattened NREG*DW; set bits self-clear one cycle after being written.
- DEFAULT_RD, 32'hDEADBEEF: returned for out-of-range addresses; replicated or truncated to DW.
- TIMEOUT, 1024: inter-byte timeout in clk cycles (macro-dependent).
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  byte from host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted on rx_valid&rx_ready.
- tx_data  out  8  byte to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  byte taken on tx_valid&tx_ready.
- reg_q  out  NREG*DW  register contents.
- reg_d  in  NREG*DW  status inputs; read only where RO_MASK is set.
- wr_strobe  out  NREG  one-cycle pulse on the register just written.
- err_cnt  out  8  saturating frame-error count.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Frame format: a command byte, then an address byte, then data bytes for writes only. Data is little-endian, LSB byte first.
  - Command byte low nibble: 4'h5 is WRITE, 4'hA is READ. The high nibble is ignored.
  - Address byte bits [ADR_W-1:0] select the register. An address byte >= NREG is out of range.
- States: IDLE, ADDR, WDATA, COMMIT, RDATA.
- IDLE: accept a byte.
  - WRITE → ADDR(wr). READ → ADDR(rd).
  - Any other command: drop it, increment err_cnt, stay in IDLE.
- ADDR: accept a byte and latch the address.
  - Write: go to WDATA and clear the byte counter.
  - Read: on the same edge, snapshot the source into the DW shift register, then go to RDATA.
  - Snapshot source: reg_d if RO_MASK[adr], DEFAULT_RD if out of range, reg_q otherwise.
- WDATA: shift in DATA_BYTES bytes. After the last byte → COMMIT.
- COMMIT: one cycle, rx_ready=0.
  - In-range, writable address: reg_q slice ← assembled word and wr_strobe[adr] is pulsed.
  - Read-only or out-of-range address: data is discarded, no strobe, err_cnt increments.
  - Then → IDLE.
- RDATA: tx_valid=1 and tx_data = shift[7:0]. On each handshake, shift right by 8. After DATA_BYTES handshakes → IDLE.
- rx_ready = 1 in IDLE, ADDR and WDATA; 0 otherwise. tx_valid = 1 only in RDATA.
- PULSE_MASK bits that were written 1 return to 0 on the edge after the commit edge. Reset values apply normally.
- err_cnt saturates at 8'hFF and is cleared only by reset.

## Timing
- Reset values:
  - state IDLE, reg_q = RESET_VAL, tx_valid = 0, tx_data = 0, wr_strobe = 0, err_cnt = 0, busy = 0, rx_ready = 1 on the first cycle after reset.
- Write latency: last data byte accepted at edge k → COMMIT during cycle k → reg_q and wr_strobe valid after edge k+1. wr_strobe deasserts at k+2, and pulse bits clear at the same edge.
- Read latency: address accepted at edge k → tx_valid high in the cycle after k. The snapshot is frozen: later changes to reg_d or reg_q do not alter the bytes in flight.
- Back-to-back frames: a command byte may be accepted in the cycle immediately after COMMIT or after the final RDATA handshake.
- tx_ready held low: tx_data and tx_valid hold steady.
- Reset mid-frame: abort the frame immediately and discard any partial write; no strobe is issued.

## Configuration
- FT_REGBANK_TIMEOUT_EN defined:
  - A 16-bit idle counter runs in ADDR, WDATA and RDATA.
  - It clears on any rx or tx handshake and on state entry.
  - On reaching TIMEOUT it aborts to IDLE, increments err_cnt, and discards partial data; no commit occurs.
- Undefined: no counter is built and the block waits indefinitely. The TIMEOUT parameter is ignored.

## Structure
- Package ft_regbank_pkg holds:
  - CMD_WRITE = 4'h5 and CMD_READ = 4'hA;
  - the state enum;
  - a helper function for the DEFAULT_RD width fit.
- One sub-module, ft_regbank_frame, contains the frame FSM, byte counter, shift registers and timeout. The top level holds the register array, snapshot mux, pulse clearing and strobes.

## Test plan
- Write 0x05,0x03,0x78,0x56,0x34,0x12 → reg_q[3] = 0x12345678 one cycle after COMMIT; wr_strobe = 16'h0008 for exactly one cycle.
- Read 0x0A,0x03 after that write → tx bytes 0x78,0x56,0x34,0x12. With tx_ready toggling 1-0-1, each byte holds until taken.
- With RO_MASK[5]=1 and reg_d[5]=0xCAFEF00D: read 0x0A,0x05 → 0x0D,0xF0,0xFE,0xCA. A write to register 5 leaves reg_q unchanged and err_cnt=1.
- Read of address 0x20 with NREG=16 → 0xEF,0xBE,0xAD,0xDE. Command byte 0x33 → dropped, err_cnt increments, busy stays 0.
- With PULSE_MASK[0] bit0 set: write 0x00000001 to register 0 → bit reads 1 for exactly one cycle, then 0.
- With FT_REGBANK_TIMEOUT_EN and TIMEOUT=16: send 0x05,0x02,0xAA, then go silent → IDLE after 16 cycles, reg_q[2] unchanged, err_cnt=1. Reset asserted mid-frame → IDLE and no strobe.
